// File: rtl/d5m_sensor_emulator_if.sv
// D5M camera parallel bus: pixel clock, 12-bit pixel data and frame/line valid.
// The sensor side drives it as master and the receiver side samples it as slave.
interface d5m_sensor_emulator_if;
    logic        pclk;
    logic [11:0] data;
    logic        fval;
    logic        lval;

    modport master (output pclk, output data, output fval, output lval);
    modport slave  (input  pclk, input  data, input  fval, input  lval);
endinterface

// File: rtl/d5m_sensor_emulator.sv
// Transmit-side D5M sensor model: derives pclk from clk and emits framed test
// patterns with fval/lval timing, changing outputs only at pclk falling edges.
module d5m_sensor_emulator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_LEAD  = 8,
    parameter int V_BLANK  = 64,
    parameter int CLK_DIV  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cam_reset_n,
    input  logic                         enable,
    input  logic [1:0]                   pattern_sel,
    d5m_sensor_emulator_if.master        cam,
    output logic [15:0]                  frame_count,
    output logic                         busy
);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int X_W     = $clog2(H_ACTIVE);
    localparam int Y_W     = $clog2(V_ACTIVE);
    localparam int CNT_MAX = (FV_LEAD > H_BLANK) ?
                             ((FV_LEAD > V_BLANK) ? FV_LEAD : V_BLANK) :
                             ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] LEAD_END = CNT_W'(FV_LEAD - 1);
    localparam logic [CNT_W-1:0] HB_END   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VB_END   = CNT_W'(V_BLANK - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEAD   = 3'd1;
    localparam logic [2:0] ACTIVE = 3'd2;
    localparam logic [2:0] HBLANK = 3'd3;
    localparam logic [2:0] VBLANK = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             tick;
    logic [X_W-1:0]   x;
    logic [X_W-1:0]   x_inc;
    logic [Y_W-1:0]   y;
    logic [Y_W-1:0]   y_inc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       pat;
    logic [11:0]      snap;
    logic             pclk_q;
    logic [11:0]      data_q;
    logic             fval_q;
    logic             lval_q;

    // Bayer order matches the D5M: G1 R on even rows, B G2 on odd rows.
    function automatic logic [11:0] pixel(input logic [1:0] sel,
                                          input logic [X_W-1:0] px,
                                          input logic [Y_W-1:0] py,
                                          input logic [11:0] fc);
        logic [11:0] r;
        case (sel)
            2'd0:    r = {6'(py), 6'(px)};
            2'd1: begin
                case ({py[0], px[0]})
                    2'b00:   r = 12'h800;
                    2'b01:   r = 12'hFFF;
                    2'b10:   r = 12'h000;
                    default: r = 12'h800;
                endcase
            end
            2'd2:    r = fc;
            default: r = 12'hAAA;
        endcase
        return r;
    endfunction

    assign tick    = (div == DIV_LAST);
    assign div_nxt = tick ? '0 : div + DIV_W'(1);
    assign x_inc   = x + X_W'(1);
    assign y_inc   = y + Y_W'(1);
    assign cnt_inc = cnt + CNT_W'(1);

    assign cam.pclk = pclk_q;
    assign cam.data = data_q;
    assign cam.fval = fval_q;
    assign cam.lval = lval_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div         <= '0;
            pclk_q      <= 1'b0;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            pat         <= 2'd0;
            snap        <= 12'd0;
            data_q      <= 12'd0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            frame_count <= 16'd0;
        end else if (!cam_reset_n) begin
            state       <= IDLE;
            div         <= '0;
            pclk_q      <= 1'b0;
            x           <= '0;
            y           <= '0;
            cnt         <= '0;
            pat         <= 2'd0;
            snap        <= 12'd0;
            data_q      <= 12'd0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            div    <= div_nxt;
            pclk_q <= (div_nxt >= DIV_HALF);
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state  <= LEAD;
                            fval_q <= 1'b1;
                            pat    <= pattern_sel;
                            snap   <= frame_count[11:0];
                            x      <= '0;
                            y      <= '0;
                            cnt    <= '0;
                        end
                    end
                    LEAD: begin
                        if (cnt == LEAD_END) begin
                            state  <= ACTIVE;
                            lval_q <= 1'b1;
                            x      <= '0;
                            data_q <= pixel(pat, '0, y, snap);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ACTIVE: begin
                        if (x == X_LAST) begin
                            state  <= HBLANK;
                            lval_q <= 1'b0;
                            data_q <= 12'd0;
                            cnt    <= '0;
                        end else begin
                            x      <= x_inc;
                            data_q <= pixel(pat, x_inc, y, snap);
                        end
                    end
                    HBLANK: begin
                        if (cnt != HB_END) begin
                            cnt <= cnt_inc;
                        end else if (y != Y_LAST) begin
                            state  <= ACTIVE;
                            lval_q <= 1'b1;
                            x      <= '0;
                            y      <= y_inc;
                            data_q <= pixel(pat, '0, y_inc, snap);
                        end else begin
                            state       <= VBLANK;
                            fval_q      <= 1'b0;
                            cnt         <= '0;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                    VBLANK: begin
                        if (cnt != VB_END) begin
                            cnt <= cnt_inc;
                        end else if (enable) begin
                            state  <= LEAD;
                            fval_q <= 1'b1;
                            pat    <= pattern_sel;
                            snap   <= frame_count[11:0];
                            x      <= '0;
                            y      <= '0;
                            cnt    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        fval_q <= 1'b0;
                        lval_q <= 1'b0;
                        data_q <= 12'd0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_d5m_sensor_emulator.sv
// Bench for d5m_sensor_emulator on a small 8x4 frame: a monitor captures what a
// receiver would sample at pclk rising edges, then a vector table is checked.
module tb_d5m_sensor_emulator;
    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 2;
    localparam int FV_LEAD  = 2;
    localparam int V_BLANK  = 3;
    localparam int CLK_DIV  = 2;
    localparam int FV_TICKS = FV_LEAD + V_ACTIVE * (H_ACTIVE + H_BLANK);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cam_reset_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] frame_count;
    logic        busy;

    d5m_sensor_emulator_if cam ();

    d5m_sensor_emulator #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .FV_LEAD(FV_LEAD), .V_BLANK(V_BLANK), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cam_reset_n(cam_reset_n),
        .enable(enable), .pattern_sel(pattern_sel), .cam(cam),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Receiver-side monitor, evaluated on the clk falling edge.
    bit          mon_en = 1'b0;
    logic        prev_pclk, prev_fval, prev_lval, rise;
    logic [11:0] low_data;
    logic        low_fval, low_lval;
    bit          low_v, first_run;
    int          run;
    int          frame_idx = -1;
    int          mx, my;
    bit          fok;
    logic [11:0] pix [0:7][0:3][0:7];
    int          lines [0:7];
    int          fv [0:7];
    int          lead [0:7];
    int          vb [0:7];
    int          stab_err = 0, len_err = 0, zero_err = 0, duty_err = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_pclk = cam.pclk;
            prev_fval = 1'b0;
            prev_lval = 1'b0;
            run       = 0;
            first_run = 1'b1;
            low_v     = 1'b0;
        end else begin
            rise = cam.pclk && !prev_pclk;
            if (cam.pclk == prev_pclk) begin
                run++;
            end else begin
                if (!first_run && run != CLK_DIV / 2) duty_err++;
                first_run = 1'b0;
                run = 1;
            end
            if (!cam.pclk) begin
                low_data = cam.data;
                low_fval = cam.fval;
                low_lval = cam.lval;
                low_v    = 1'b1;
            end
            if (rise) begin
                if (low_v && (cam.data !== low_data || cam.fval !== low_fval ||
                              cam.lval !== low_lval)) stab_err++;
                if (cam.fval && !prev_fval) begin
                    frame_idx++;
                    mx = 0;
                    my = 0;
                end
                fok = (frame_idx >= 0 && frame_idx < 8);
                if (cam.lval) begin
                    if (!prev_lval) mx = 0;
                    if (fok && my < 4 && mx < 8) pix[frame_idx][my][mx] = cam.data;
                    mx++;
                end else begin
                    if (cam.data !== 12'd0) zero_err++;
                    if (prev_lval) begin
                        if (mx != H_ACTIVE) len_err++;
                        if (fok) lines[frame_idx]++;
                        my++;
                    end
                end
                if (fok) begin
                    if (cam.fval) fv[frame_idx]++;
                    else vb[frame_idx]++;
                    if (cam.fval && !cam.lval && lines[frame_idx] == 0) lead[frame_idx]++;
                end
                prev_fval = cam.fval;
                prev_lval = cam.lval;
            end
            prev_pclk = cam.pclk;
        end
    end

    task automatic wait_fval(input logic lvl, input string nm);
        for (int k = 0; k < 1000 && cam.fval !== lvl; k++) @(negedge clk);
        if (cam.fval !== lvl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout %s: fval is %0b, want %0b", nm, cam.fval, lvl);
        end
    endtask

    task automatic wait_lval(input logic lvl, input string nm);
        for (int k = 0; k < 1000 && cam.lval !== lvl; k++) @(negedge clk);
        if (cam.lval !== lvl) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout %s: lval is %0b, want %0b", nm, cam.lval, lvl);
        end
    endtask

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [11:0] exp;
    } pix_vec_t;

    pix_vec_t vecs [18];
    int       stat_frames [5];
    bit       fval_seen;

    initial begin
        vecs = '{
            '{0, 0, 0, 12'h000}, '{0, 5, 3, 12'h0C5}, '{0, 7, 0, 12'h007},
            '{0, 0, 1, 12'h040}, '{0, 7, 3, 12'h0C7},
            '{1, 0, 0, 12'h800}, '{1, 1, 0, 12'hFFF}, '{1, 0, 1, 12'h000},
            '{1, 1, 1, 12'h800}, '{1, 6, 2, 12'h800}, '{1, 2, 3, 12'h000},
            '{1, 7, 0, 12'hFFF},
            '{2, 0, 0, 12'h002}, '{2, 7, 3, 12'h002},
            '{3, 0, 0, 12'hAAA}, '{3, 4, 2, 12'hAAA},
            '{5, 0, 0, 12'h000}, '{5, 5, 3, 12'h0C5}
        };
        stat_frames = '{0, 1, 2, 3, 5};
        for (int f = 0; f < 8; f++) begin
            lines[f] = 0; fv[f] = 0; lead[f] = 0; vb[f] = 0;
            for (int yy = 0; yy < 4; yy++)
                for (int xx = 0; xx < 8; xx++) pix[f][yy][xx] = 12'h5A5;
        end

        repeat (4) @(negedge clk);
        check("reset pclk", 32'(cam.pclk), 32'd0);
        check("reset data", 32'(cam.data), 32'd0);
        check("reset fval", 32'(cam.fval), 32'd0);
        check("reset lval", 32'(cam.lval), 32'd0);
        check("reset frame_count", 32'(frame_count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);

        enable = 1'b1;
        pattern_sel = 2'd0;
        reset_n = 1'b1;
        mon_en = 1'b1;

        wait_fval(1'b1, "f0 start");
        pattern_sel = 2'd1;
        wait_fval(1'b0, "f0 end");
        check("frame_count after f0", 32'(frame_count), 32'd1);
        wait_fval(1'b1, "f1 start");
        pattern_sel = 2'd2;
        wait_fval(1'b0, "f1 end");
        wait_fval(1'b1, "f2 start");
        pattern_sel = 2'd3;
        wait_fval(1'b0, "f2 end");
        wait_fval(1'b1, "f3 start");
        pattern_sel = 2'd0;
        wait_lval(1'b1, "f3 line0");
        wait_lval(1'b0, "f3 line0 end");
        wait_lval(1'b1, "f3 line1");
        enable = 1'b0;
        wait_fval(1'b0, "f3 end");
        check("frame_count after f3", 32'(frame_count), 32'd4);
        check("busy in vblank", 32'(busy), 32'd1);

        fval_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cam.fval) fval_seen = 1'b1;
        end
        check("fval after disable", 32'(fval_seen), 32'd0);
        check("busy after disable", 32'(busy), 32'd0);
        check("frame_count idle", 32'(frame_count), 32'd4);

        enable = 1'b1;
        wait_fval(1'b1, "f4 start");
        wait_lval(1'b1, "f4 line0");
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        cam_reset_n = 1'b0;
        @(negedge clk);
        check("cam_reset fval", 32'(cam.fval), 32'd0);
        check("cam_reset lval", 32'(cam.lval), 32'd0);
        check("cam_reset data", 32'(cam.data), 32'd0);
        check("cam_reset pclk", 32'(cam.pclk), 32'd0);
        check("cam_reset frame_count", 32'(frame_count), 32'd0);
        check("cam_reset busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        cam_reset_n = 1'b1;
        mon_en = 1'b1;
        wait_fval(1'b1, "f5 start");
        wait_fval(1'b0, "f5 end");
        check("frame_count after f5", 32'(frame_count), 32'd1);
        enable = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 18; i++)
            check($sformatf("pix f%0d x%0d y%0d", vecs[i].f, vecs[i].x, vecs[i].y),
                  32'(pix[vecs[i].f][vecs[i].y][vecs[i].x]), 32'(vecs[i].exp));
        foreach (stat_frames[i]) begin
            check($sformatf("lval pulses f%0d", stat_frames[i]), lines[stat_frames[i]], V_ACTIVE);
            check($sformatf("fval ticks f%0d", stat_frames[i]), fv[stat_frames[i]], FV_TICKS);
            check($sformatf("lead ticks f%0d", stat_frames[i]), lead[stat_frames[i]], FV_LEAD);
        end
        for (int f = 0; f < 3; f++)
            check($sformatf("vblank ticks f%0d", f), vb[f], V_BLANK);
        check("line length errors", len_err, 0);
        check("data stability errors", stab_err, 0);
        check("nonzero blank data", zero_err, 0);
        check("pclk duty errors", duty_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/d5m_sensor_emulator.md
Name: d5m_sensor_emulator

Overview:
- Transmit-side model of the D5M camera parallel interface: generates pclk, 12-bit pixel data, fval and lval with D5M framing.
- Drives a d5m_top camera receiver directly, in place of the physical sensor. Used for on-board bring-up of the capture path and for receiver verification.
- Synthesizable. Runs on the system clock; pclk is derived internally.

Parameters:
- H_ACTIVE, 640: active pixels per line (>=2, even).
- V_ACTIVE, 480: active lines per frame (>=2, even).
- H_BLANK, 16: pixel times with lval low between lines, and after the last line before fval falls (>=1).
- FV_LEAD, 8: pixel times with fval high and lval low before the first line (>=1).
- V_BLANK, 64: pixel times with fval low between frames (>=1).
- CLK_DIV, 2: clk cycles per pixel period (even, >=2).

Ports:
- clk, in, 1: system clock; also acts as the camera mclk.
- reset_n, in, 1: asynchronous active-low reset.
- cam_reset_n, in, 1: sensor reset from the receiver (cam_reset). Synchronous, active-low; when low, behaves as reset.
- enable, in, 1: generate frames while high.
- pattern_sel, in, 2: test pattern select, latched at frame start.
- pclk, out, 1: pixel clock.
- data, out, 12: pixel data.
- fval, out, 1: frame valid.
- lval, out, 1: line valid.
- frame_count, out, 16: number of completed frames; wraps.
- busy, out, 1: high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset (reset_n low, or cam_reset_n low at a clk edge):
  - pclk=0, data=0, fval=0, lval=0, frame_count=0, busy=0.
  - State IDLE; all counters cleared.
  - Asserting reset mid-frame aborts the frame immediately; the next frame restarts from the beginning.
- Pixel timing:
  - div counter runs 0..CLK_DIV-1 continuously out of reset.
  - pclk is registered, and equals 1 when div >= CLK_DIV/2.
  - A pixel tick occurs when div wraps to 0, i.e. at the pclk falling edge.
  - data, fval and lval change only on ticks, so they are stable across the pclk rising edge where the receiver samples.
- FSM (advances on ticks only):
  - IDLE: fval=0, lval=0, data=0. Goes to LEAD when enable=1; latches pattern_sel; clears x and y.
  - LEAD: fval=1, lval=0. Stays for FV_LEAD ticks, then goes to ACTIVE.
  - ACTIVE: fval=1, lval=1, data=pattern(x,y). Stays for H_ACTIVE ticks; x increments each tick. After x=H_ACTIVE-1, goes to HBLANK.
  - HBLANK: fval=1, lval=0, data=0. Stays for H_BLANK ticks. If y<V_ACTIVE-1: y++, x=0, go to ACTIVE. Otherwise go to VBLANK.
  - VBLANK: fval=0, lval=0. On entry, frame_count increments (wrapping 0xFFFF->0). Stays for V_BLANK ticks. Then goes to LEAD if enable=1 (re-latching pattern_sel), else to IDLE.
- Every frame delivers exactly V_ACTIVE lval pulses, each exactly H_ACTIVE ticks long.
- enable is sampled only in IDLE and at the end of VBLANK. Deasserting it mid-frame completes the current frame.
- Patterns (x, y are 0-based within the active region; data=0 outside ACTIVE):
  - 0: ramp, data = {y[5:0], x[5:0]}.
  - 1: Bayer bars, per D5M order (G1 R / B G2):
    - even y, even x: 0x800
    - even y, odd x: 0xFFF
    - odd y, even x: 0x000
    - odd y, odd x: 0x800
  - 2: constant frame_count[11:0] value at frame start.
  - 3: constant 0xAAA.
- A pattern_sel change mid-frame takes effect at the next frame.
- Counter widths must hold H_ACTIVE-1, V_ACTIVE-1 and max(FV_LEAD, H_BLANK, V_BLANK) without overflow.

Test Plan:
- Defaults, CLK_DIV=2, enable=1, pattern 0 -> pclk period 2 clk. fval high for 8 + 480*(640+16) = 314888 ticks. 480 lval pulses of 640 ticks each. frame_count goes 0->1 at fval fall. First pixel 0x000, pixel (x=5,y=3) = 0x0C5.
- Small config H_ACTIVE=4, V_ACTIVE=2, pattern 1 -> line 0 data 0x800,0xFFF,0x800,0xFFF; line 1 data 0x000,0x800,0x000,0x800. Data is stable at every pclk rising edge.
- enable dropped during line 1 of frame 0 -> frame completes with full line count. After V_BLANK ticks: fval stays 0, busy=0, frame_count=1.
- pattern_sel changed 2->3 mid-frame 1 -> frame 1 data is constant 0x001; frame 2 data is constant 0xAAA.
- cam_reset_n pulsed low during ACTIVE -> next clk: fval=lval=0, data=0, frame_count=0. After release, a full frame is generated starting with LEAD.
- Counter wrap with CLK_DIV=4 and tiny frames, 65537 frames run -> frame_count reads 1. pclk duty cycle is 2 high / 2 low throughout.
